uart_rx: RTL and testbench

// - Serial receive stage of the APB-UART; the counterpart of uart_tx on the line side.
// - Oversamples rx on a 16x baud tick and deframes 5..8 data bits, optional parity and 1/2 stop bits.
// - Presents each received word, with parity/framing/overrun status, to the register/FIFO layer.
// - Drives rts_n_o for hardware flow control.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Register/FIFO-side bundle of the UART receiver: frame configuration in, received word and
// status out.
interface uart_rx_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        data_bit_num_i;
  logic              parity_en_i;
  logic              parity_type_i;
  logic              stop_bit_num_i;
  logic              rx_read_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_done_o;
  logic              parity_err_o;
  logic              frame_err_o;
  logic              overrun_err_o;
  logic              rx_full_o;
  logic              rts_n_o;

  modport slave (
    input  data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_read_i,
    output rx_data_o, rx_done_o, parity_err_o, frame_err_o, overrun_err_o, rx_full_o, rts_n_o
  );

  modport master (
    output data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_read_i,
    input  rx_data_o, rx_done_o, parity_err_o, frame_err_o, overrun_err_o, rx_full_o, rts_n_o
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchroniser, oversampled deframer (5..8 data bits, optional
// parity, 1/2 stop bits) and a single-word holding register with overrun detection.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_tick,
  input  logic     rx,
  uart_rx_if.slave bus
);
  localparam int unsigned      TickW    = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q;
  logic              rx_meta_q;
  logic              rxs_q;
  logic              armed_q;
  logic [TickW-1:0]  tick_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic              stop_cnt_q;
  logic [7:0]        shift_q;
  logic [1:0]        dbn_q;
  logic              par_en_q;
  logic              par_type_q;
  logic              stop2_q;
  logic              par_err_q;
  logic              frm_err_q;
  logic              commit_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_done_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              full_q;

  logic sample_half;
  logic sample_full;
  assign sample_half = rx_tick && (tick_cnt_q == TickHalf);
  assign sample_full = rx_tick && (tick_cnt_q == TickLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      armed_q      <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      dbn_q        <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      stop2_q      <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      commit_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      rx_done_q <= 1'b0;
      commit_q  <= 1'b0;
      if (rx_tick) tick_cnt_q <= tick_cnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          tick_cnt_q <= '0;
          // Arming on a high line keeps a held-low break from retriggering frames.
          if (rxs_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= StStart;
            dbn_q      <= bus.data_bit_num_i;
            par_en_q   <= bus.parity_en_i;
            par_type_q <= bus.parity_type_i;
            stop2_q    <= bus.stop_bit_num_i;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end
        StStart: begin
          if (sample_half) begin
            tick_cnt_q <= '0;
            if (rxs_q) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              armed_q <= 1'b0;
            end
          end
        end
        StData: begin
          if (sample_full) begin
            tick_cnt_q         <= '0;
            shift_q[bit_cnt_q] <= rxs_q;
            bit_cnt_q          <= bit_cnt_q + 1'b1;
            // Last index is 4..7 for 5..8 bits, i.e. {1, data_bit_num}.
            if (bit_cnt_q == {1'b1, dbn_q}) state_q <= par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          if (sample_full) begin
            tick_cnt_q <= '0;
            par_err_q  <= (^shift_q) ^ rxs_q ^ par_type_q;
            state_q    <= StStop;
          end
        end
        StStop: begin
          if (sample_full) begin
            tick_cnt_q <= '0;
            stop_cnt_q <= 1'b1;
            if (!rxs_q) frm_err_q <= 1'b1;
            // Leave mid-stop-bit so the next start edge has half a bit of slack.
            if (stop_cnt_q == stop2_q) begin
              state_q  <= StIdle;
              commit_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (bus.rx_read_i) begin
        full_q    <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (commit_q) begin
        if (!full_q || bus.rx_read_i) begin
          rx_data_q    <= DATA_W'(shift_q);
          parity_err_q <= par_err_q;
          frame_err_q  <= frm_err_q;
          rx_done_q    <= 1'b1;
          full_q       <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_done_o     = rx_done_q;
  assign bus.parity_err_o  = parity_err_q;
  assign bus.frame_err_o   = frame_err_q;
  assign bus.overrun_err_o = overrun_q;
  assign bus.rx_full_o     = full_q;
  assign bus.rts_n_o       = full_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven at 16 ticks/bit, 14 clk/tick.
module tb_uart_rx;
  localparam int unsigned BitClks = 16 * 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_tick = 1'b0;
  logic rx = 1'b1;
  int   tick_div = 0;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic dbl_done = 1'b0;

  uart_rx_if #(.DATA_W(32)) bus ();

  uart_rx #(
    .OVERSAMPLE(16),
    .DATA_W    (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_tick(rx_tick),
    .rx     (rx),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (tick_div == 13) begin
      tick_div <= 0;
      rx_tick  <= 1'b1;
    end else begin
      tick_div <= tick_div + 1;
      rx_tick  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.rx_done_o) begin
      done_cnt = done_cnt + 1;
      if (prev_done) dbl_done = 1'b1;
    end
    prev_done = bus.rx_done_o;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int bits);
    rx = v;
    clks(bits * BitClks);
  endtask

  task automatic cfg(input logic [1:0] dbn, input logic pen, input logic ptype, input logic st2);
    bus.data_bit_num_i = dbn;
    bus.parity_en_i    = pen;
    bus.parity_type_i  = ptype;
    bus.stop_bit_num_i = st2;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input int nstop, input logic stop_v);
    line(1'b0, 1);
    for (int i = 0; i < nbits; i++) line(d[i], 1);
    if (pen) line(pbit, 1);
    for (int s = 0; s < nstop; s++) line(stop_v, 1);
    rx = 1'b1;
  endtask

  task automatic read_word();
    bus.rx_read_i = 1'b1;
    clks(1);
    bus.rx_read_i = 1'b0;
    clks(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(1);
    vectors++;
    if (bus.rx_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h exp %h", bus.rx_data_o, 32'h0);
    end
    vectors++;
    if ({bus.rx_done_o, bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o, bus.rx_full_o,
         bus.rts_n_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp %b", {bus.rx_done_o, bus.parity_err_o,
               bus.frame_err_o, bus.overrun_err_o, bus.rx_full_o, bus.rts_n_o}, 6'b0);
    end
    clks(2 * BitClks);
  endtask

  task automatic test_8n1();
    int d0;
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    line(1'b1, 1);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL 8n1_done_count got %0d exp 1", done_cnt - d0);
    end
    vectors++;
    if (bus.rx_data_o !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL 8n1_data got %h exp %h", bus.rx_data_o, 32'h0000_00A5);
    end
    vectors++;
    if ({bus.parity_err_o, bus.frame_err_o, bus.rx_full_o, bus.rts_n_o} !== 4'b0011) begin
      miscompares++;
      $display("FAIL 8n1_flags got %b exp %b", {bus.parity_err_o, bus.frame_err_o,
               bus.rx_full_o, bus.rts_n_o}, 4'b0011);
    end
    read_word();
    vectors++;
    if ({bus.rx_full_o, bus.rts_n_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL 8n1_read_full got %b exp %b", {bus.rx_full_o, bus.rts_n_o}, 2'b00);
    end
  endtask

  task automatic test_parity();
    cfg(2'b10, 1'b1, 1'b0, 1'b1);
    send_frame(8'h7F, 7, 1'b1, 1'b1, 2, 1'b1);
    line(1'b1, 1);
    vectors++;
    if (bus.rx_data_o !== 32'h7F) begin
      miscompares++;
      $display("FAIL 7e2_data got %h exp %h", bus.rx_data_o, 32'h7F);
    end
    vectors++;
    if ({bus.parity_err_o, bus.frame_err_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL 7e2_good_parity got %b exp %b", {bus.parity_err_o, bus.frame_err_o}, 2'b00);
    end
    read_word();
    send_frame(8'h7F, 7, 1'b1, 1'b0, 2, 1'b1);
    line(1'b1, 1);
    vectors++;
    if ({bus.parity_err_o, bus.frame_err_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL 7e2_bad_parity got %b exp %b", {bus.parity_err_o, bus.frame_err_o}, 2'b10);
    end
    read_word();
  endtask

  task automatic test_frame_err();
    int d0;
    cfg(2'b01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 6, 1'b1, 1'b1, 1, 1'b0);
    line(1'b1, 1);
    vectors++;
    if (bus.rx_data_o !== 32'h3C) begin
      miscompares++;
      $display("FAIL 6o1_data got %h exp %h", bus.rx_data_o, 32'h3C);
    end
    vectors++;
    if ({bus.parity_err_o, bus.frame_err_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL 6o1_frame_err got %b exp %b", {bus.parity_err_o, bus.frame_err_o}, 2'b01);
    end
    read_word();
    // Break: 20 bit times low, then idle.
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    line(1'b0, 20);
    line(1'b1, 2);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL break_done_count got %0d exp 1", done_cnt - d0);
    end
    vectors++;
    if (bus.rx_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL break_data got %h exp %h", bus.rx_data_o, 32'h0);
    end
    vectors++;
    if (bus.frame_err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL break_frame_err got %b exp %b", bus.frame_err_o, 1'b1);
    end
    read_word();
  endtask

  task automatic test_glitch();
    int d0;
    d0 = done_cnt;
    rx = 1'b0;
    clks(3 * 14);
    line(1'b1, 2);
    vectors++;
    if (done_cnt - d0 != 0) begin
      miscompares++;
      $display("FAIL glitch_done_count got %0d exp 0", done_cnt - d0);
    end
    vectors++;
    if ({bus.rx_data_o, bus.frame_err_o, bus.rx_full_o} !== {32'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL glitch_outputs got %h/%b/%b exp 0/1/0", bus.rx_data_o, bus.frame_err_o,
               bus.rx_full_o);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    line(1'b1, 1);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL overrun_done_count got %0d exp 1", done_cnt - d0);
    end
    vectors++;
    if (bus.rx_data_o !== 32'h11) begin
      miscompares++;
      $display("FAIL overrun_data got %h exp %h", bus.rx_data_o, 32'h11);
    end
    vectors++;
    if ({bus.overrun_err_o, bus.rts_n_o, bus.rx_full_o} !== 3'b111) begin
      miscompares++;
      $display("FAIL overrun_flags got %b exp %b", {bus.overrun_err_o, bus.rts_n_o,
               bus.rx_full_o}, 3'b111);
    end
    read_word();
    vectors++;
    if ({bus.overrun_err_o, bus.rx_full_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL overrun_read got %b exp %b", {bus.overrun_err_o, bus.rx_full_o}, 2'b00);
    end
    vectors++;
    if (dbl_done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_single_cycle got %b exp %b", dbl_done, 1'b0);
    end
  endtask

  task automatic test_rst_mid_frame();
    int d0;
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    line(1'b0, 1);
    line(1'b1, 1);
    line(1'b0, 1);
    line(1'b1, 1);
    rx = 1'b0;
    clks(BitClks / 2);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    rx  = 1'b1;
    vectors++;
    if ({bus.rx_data_o, bus.rx_done_o, bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o,
         bus.rx_full_o, bus.rts_n_o} !== 38'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got data %h flags %b exp all 0", bus.rx_data_o,
               {bus.rx_done_o, bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o,
                bus.rx_full_o, bus.rts_n_o});
    end
    clks(6 * BitClks);
    vectors++;
    if (done_cnt - d0 != 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_done got %0d exp 0", done_cnt - d0);
    end
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    line(1'b1, 1);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL rst_next_done got %0d exp 1", done_cnt - d0);
    end
    vectors++;
    if ({bus.rx_data_o, bus.frame_err_o, bus.parity_err_o} !== {32'h5A, 2'b00}) begin
      miscompares++;
      $display("FAIL rst_next_data got %h/%b/%b exp 5a/0/0", bus.rx_data_o, bus.frame_err_o,
               bus.parity_err_o);
    end
  endtask

  initial begin
    bus.data_bit_num_i = 2'b11;
    bus.parity_en_i    = 1'b0;
    bus.parity_type_i  = 1'b0;
    bus.stop_bit_num_i = 1'b0;
    bus.rx_read_i      = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_rst_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout vectors %0d", vectors);
    $fatal(1, "watchdog");
  end
endmodule
